// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : instr_encoder
// Purpose  : Packs decoded RV32I fields into instruction words and writes them
//            to consecutive instruction-memory addresses via a one-deep register.
// Revision : 1.0
// ============================================================================
module instr_encoder #(
    parameter int                ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [2:0]        in_fmt,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              done,
    output logic [15:0]       wr_count,
    output logic [15:0]       err_count,
    output logic              err
);

    localparam logic [2:0] c_FMT_R  = 3'd0;
    localparam logic [2:0] c_FMT_I  = 3'd1;
    localparam logic [2:0] c_FMT_SH = 3'd2;
    localparam logic [2:0] c_FMT_S  = 3'd3;
    localparam logic [2:0] c_FMT_B  = 3'd4;
    localparam logic [2:0] c_FMT_U  = 3'd5;
    localparam logic [2:0] c_FMT_J  = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_RUN       = 2'd1,
        S_LAST_PEND = 2'd2,
        S_DONE      = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_we;
    logic [ADDR_W-1:0]  r_addr;
    logic [31:0]        r_wdata;
    logic [15:0]        r_wr_count;
    logic [15:0]        r_err_count;
    logic               r_err;

    logic               w_start;
    logic               w_accept;
    logic               w_complete;
    logic               w_legal;
    logic [31:0]        w_word;
    logic               w_fits12;
    logic               w_fits13;
    logic               w_fits21;

    // Sign-extension checks: all bits above the field's sign bit must match it.
    assign w_fits12   = (in_imm[31:11] == '0) || (in_imm[31:11] == '1);
    assign w_fits13   = (in_imm[31:12] == '0) || (in_imm[31:12] == '1);
    assign w_fits21   = (in_imm[31:20] == '0) || (in_imm[31:20] == '1);

    assign w_start    = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign in_ready   = (r_state == S_RUN) && (!r_we || mem_ready);
    assign w_accept   = in_valid && in_ready;
    assign w_complete = r_we && mem_ready;

    always_comb begin
        w_word  = '0;
        w_legal = 1'b1;
        case (in_fmt)
            c_FMT_R: w_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
            c_FMT_I: begin
                w_word  = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
                w_legal = w_fits12;
            end
            c_FMT_SH: begin
                w_word  = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, in_opcode};
                w_legal = (in_imm[31:5] == '0);
            end
            c_FMT_S: begin
                w_word  = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
                w_legal = w_fits12;
            end
            c_FMT_B: begin
                w_word  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                           in_imm[4:1], in_imm[11], in_opcode};
                w_legal = w_fits13 && !in_imm[0];
            end
            c_FMT_U: begin
                w_word  = {in_imm[31:12], in_rd, in_opcode};
                w_legal = (in_imm[11:0] == '0);
            end
            c_FMT_J: begin
                w_word  = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
                w_legal = w_fits21 && !in_imm[0];
            end
            default: w_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (start) w_state_nxt = S_RUN;
            S_RUN: begin
                // A dropped final bundle with the output register draining goes straight to DONE.
                if (w_accept && in_last) begin
                    w_state_nxt = (!w_legal && (!r_we || w_complete)) ? S_DONE : S_LAST_PEND;
                end
            end
            S_LAST_PEND: if (!r_we || w_complete) w_state_nxt = S_DONE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we        <= 1'b0;
            r_addr      <= BASE_ADDR;
            r_wdata     <= '0;
            r_wr_count  <= '0;
            r_err_count <= '0;
            r_err       <= 1'b0;
        end else if (w_start) begin
            r_addr      <= BASE_ADDR;
            r_wr_count  <= '0;
            r_err_count <= '0;
            r_err       <= 1'b0;
        end else begin
            // r_addr always names the word held (or next to be held) in the output register.
            if (w_complete) begin
                r_addr <= r_addr + ADDR_W'(4);
                if (r_wr_count != 16'hFFFF) r_wr_count <= r_wr_count + 16'd1;
            end
            if (w_accept && w_legal) begin
                r_we    <= 1'b1;
                r_wdata <= w_word;
            end else if (w_complete) begin
                r_we    <= 1'b0;
            end
            if (w_accept && !w_legal) begin
                r_err <= 1'b1;
                if (r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
            end
        end
    end

    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign done      = (r_state == S_DONE);
    assign wr_count  = r_wr_count;
    assign err_count = r_err_count;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: doc/instr_encoder.md
# instr_encoder

Sequential RISC-V RV32I instruction encoder and instruction-memory writer: the inverse of the core's instruction decoder. It accepts decoded instruction fields (format, opcode, rd, rs1, rs2, funct3, funct7, 32-bit immediate) over a valid/ready stream, packs them into 32-bit instruction words, and writes them to consecutive instruction-memory addresses through a one-deep output register. It sits between the test/boot loader and instruction memory. It range-checks immediates and drops illegal items, counting them.

## Interface
- ADDR_W, 16, byte-address width of instruction memory
- BASE_ADDR, 0, first write address after `start`; multiple of 4
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse: reload address to BASE_ADDR, clear counters, enter RUN; honoured only in IDLE or DONE
- in_valid  in  1  field bundle valid
- in_ready  out  1  bundle accepted on in_valid && in_ready
- in_last  in  1  marks final bundle of the program
- in_fmt  in  3  0=R, 1=I, 2=I_SHIFT, 3=S, 4=B, 5=U, 6=J, 7=illegal
- in_opcode  in  7  opcode field
- in_rd, in_rs1, in_rs2  in  5 each  register fields
- in_funct3  in  3; in_funct7  in  7
- in_imm  in  32  signed immediate (byte offset for B/J, full value for U)
- mem_we  out  1  write request (valid)
- mem_ready  in  1  memory accepts write on mem_we && mem_ready
- mem_addr  out  ADDR_W  byte address
- mem_wdata  out  32  encoded instruction
- done  out  1  high in DONE
- wr_count  out  16  words written since start
- err_count  out  16  bundles dropped since start
- err  out  1  sticky, set by any drop, cleared by start

## Operation
- States: IDLE, RUN, DONE. Reset -> IDLE. start in IDLE/DONE -> RUN. Accepting in_last -> LAST_PEND; from there -> DONE once the output register is empty (immediately if the last bundle was dropped and no write pending). DONE holds until start. start in RUN ignored.
- Encoding (bit concatenation, MSB first):
  - R: funct7, rs2, rs1, funct3, rd, opcode
  - I: imm[11:0], rs1, funct3, rd, opcode
  - I_SHIFT: funct7, imm[4:0], rs1, funct3, rd, opcode
  - S: imm[11:5], rs2, rs1, funct3, imm[4:0], opcode
  - B: imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode
  - U: imm[31:12], rd, opcode
  - J: imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode
- Drop conditions: I/S imm outside [-2048, 2047]; B imm outside [-4096, 4094] or imm[0]=1; J imm outside [-2^20, 2^20-2] or imm[0]=1; U imm[11:0] != 0; I_SHIFT imm[31:5] != 0; fmt=7. A dropped bundle is consumed (handshake completes), not written, and does not advance the address. err_count +1 (saturates at 0xFFFF); err set.
- Address advances by 4 per completed write; wraps modulo 2^ADDR_W. wr_count saturates at 0xFFFF.

## Timing
- Reset values: in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, done=0, wr_count=0, err_count=0, err=0, state IDLE.
- in_ready = (state==RUN) && (!mem_we || mem_ready); combinational from state and mem_ready.
- Latency: bundle accepted at edge N -> mem_we=1 with mem_addr/mem_wdata stable from after edge N through the edge at which mem_ready=1.
- mem_we, mem_addr, mem_wdata must not change while mem_we && !mem_ready.
- Throughput: one word per cycle with mem_ready held high (simultaneous write completion and new accept in one cycle).
- done rises the cycle after the last write completes (or after the last bundle is accepted, if it is dropped with nothing pending).
- rst_n low mid-transfer: pending write abandoned, all outputs to reset values immediately.

## Test plan
- start, fmt=I opcode=0x13 rd=1 rs1=0 funct3=0 imm=5 last=1, mem_ready=1 -> one write 0x00500093 at addr 0, done=1, wr_count=1.
- Stream S(sw x2,8(x1)), B(beq x0,x0,-4), U(lui x5, imm=0x12345000), J(jal x1, imm=8) back-to-back -> 0x0020A423@0, 0xFE000EE3@4, 0x123452B7@8, 0x008000EF@12, one per cycle.
- mem_ready low 3 cycles during second write -> mem_we/addr/data held stable, in_ready=0, no bundle lost or duplicated.
- B with imm=3, then I with imm=4096, then valid I -> first two dropped, err=1, err_count=2, valid word written at BASE_ADDR.
- ADDR_W=4, 5 bundles -> addresses 0,4,8,12,0 (wrap).
- rst_n asserted while mem_we=1 && mem_ready=0 -> mem_we=0, state IDLE, counters 0; start restarts at BASE_ADDR.
